// File: rtl/limit_modeselect.sv
// Limit/mode controller for the BCD up-counter: button-cycled modes, BCD-checked limit capture.
// Optional LIMIT_WINDOW_EN adds the min limit and WINDOW mode; default build cycles OFF/CARRY/MAX.
module limit_modeselect #(
    parameter int unsigned DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   cnt_in,
    input  logic                  mode_btn,
    input  logic                  store_max,
    input  logic                  store_min,
    output logic [1:0]            mode,
    output logic [4*DIGITS-1:0]   max_out,
    output logic [4*DIGITS-1:0]   min_out,
    output logic                  carry_en,
    output logic                  max_en,
    output logic                  min_en,
    output logic                  limit_hit,
    output logic                  store_err
);

    localparam int unsigned W = 4 * DIGITS;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_CARRY  = 2'd1,
        MODE_MAX    = 2'd2,
        MODE_WINDOW = 2'd3
    } mode_e;

    mode_e          mode_q, mode_d;
    logic           btn_q;
    logic [W-1:0]   max_lim_q, max_lim_d;
    logic [W-1:0]   max_out_q, max_out_d;
    logic [W-1:0]   min_out_q, min_out_d;
    logic           carry_en_q, carry_en_d;
    logic           max_en_q, max_en_d;
    logic           min_en_q, min_en_d;
    logic           hit_q, hit_d;
    logic           err_q, err_d;
    logic           cnt_bcd_c;
    logic           advance_c;

`ifdef LIMIT_WINDOW_EN
    logic [W-1:0]   min_lim_q, min_lim_d;
`else
    logic           unused_store_min;
    assign unused_store_min = store_min;
`endif

    // Every digit of the live count must be 0..9 for a capture to be accepted.
    always_comb begin
        cnt_bcd_c = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (cnt_in[4*k +: 4] > 4'd9) begin
                cnt_bcd_c = 1'b0;
            end
        end
    end

    assign advance_c = mode_btn & ~btn_q;

    // Next-state: mode, limits, then outputs decoded from the next-state values.
    always_comb begin
        mode_d     = mode_q;
        max_lim_d  = max_lim_q;
        max_out_d  = '0;
        min_out_d  = '0;
        carry_en_d = 1'b0;
        max_en_d   = 1'b0;
        min_en_d   = 1'b0;

        if (advance_c) begin
`ifdef LIMIT_WINDOW_EN
            mode_d = mode_e'(2'(mode_q + 2'd1));
`else
            mode_d = (mode_q == MODE_MAX) ? MODE_OFF : mode_e'(2'(mode_q + 2'd1));
`endif
        end

        if (store_max && cnt_bcd_c) begin
            max_lim_d = cnt_in;
        end

`ifdef LIMIT_WINDOW_EN
        min_lim_d = min_lim_q;
        if (store_min && cnt_bcd_c) begin
            min_lim_d = cnt_in;
        end
        err_d = (store_max | store_min) & ~cnt_bcd_c;
`else
        err_d = store_max & ~cnt_bcd_c;
`endif

        case (mode_d)
            MODE_OFF: begin
            end
            MODE_CARRY: begin
                carry_en_d = 1'b1;
                for (int unsigned k = 0; k < DIGITS; k++) begin
                    max_out_d[4*k +: 4] = (max_lim_d[4*k +: 4] != 4'd0) ? 4'd1 : 4'd0;
                end
            end
            MODE_MAX: begin
                max_out_d = max_lim_d;
                max_en_d  = 1'b1;
            end
            MODE_WINDOW: begin
                max_out_d = max_lim_d;
                max_en_d  = 1'b1;
`ifdef LIMIT_WINDOW_EN
                // An inverted window degrades to plain MAX behaviour.
                if (min_lim_d <= max_lim_d) begin
                    min_en_d  = 1'b1;
                    min_out_d = min_lim_d;
                end
`endif
            end
        endcase

        hit_d = max_en_q && (cnt_in == max_lim_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q     <= MODE_OFF;
            btn_q      <= 1'b0;
            max_lim_q  <= '0;
            max_out_q  <= '0;
            min_out_q  <= '0;
            carry_en_q <= 1'b0;
            max_en_q   <= 1'b0;
            min_en_q   <= 1'b0;
            hit_q      <= 1'b0;
            err_q      <= 1'b0;
`ifdef LIMIT_WINDOW_EN
            min_lim_q  <= '0;
`endif
        end else begin
            mode_q     <= mode_d;
            btn_q      <= mode_btn;
            max_lim_q  <= max_lim_d;
            max_out_q  <= max_out_d;
            min_out_q  <= min_out_d;
            carry_en_q <= carry_en_d;
            max_en_q   <= max_en_d;
            min_en_q   <= min_en_d;
            hit_q      <= hit_d;
            err_q      <= err_d;
`ifdef LIMIT_WINDOW_EN
            min_lim_q  <= min_lim_d;
`endif
        end
    end

    assign mode      = mode_q;
    assign max_out   = max_out_q;
    assign min_out   = min_out_q;
    assign carry_en  = carry_en_q;
    assign max_en    = max_en_q;
    assign min_en    = min_en_q;
    assign limit_hit = hit_q;
    assign store_err = err_q;

endmodule

// File: tb/tb_limit_modeselect.sv
// Directed bench for limit_modeselect: expected outputs queued per step, popped and checked after the edge.
module tb_limit_modeselect;

    logic        clk;
    logic        reset;
    logic [23:0] cnt_in;
    logic        mode_btn;
    logic        store_max;
    logic        store_min;
    logic [1:0]  mode;
    logic [23:0] max_out;
    logic [23:0] min_out;
    logic        carry_en;
    logic        max_en;
    logic        min_en;
    logic        limit_hit;
    logic        store_err;

    limit_modeselect #(.DIGITS(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .cnt_in    (cnt_in),
        .mode_btn  (mode_btn),
        .store_max (store_max),
        .store_min (store_min),
        .mode      (mode),
        .max_out   (max_out),
        .min_out   (min_out),
        .carry_en  (carry_en),
        .max_en    (max_en),
        .min_en    (min_en),
        .limit_hit (limit_hit),
        .store_err (store_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [23:0] max_out;
        logic [23:0] min_out;
        logic        carry_en;
        logic        max_en;
        logic        min_en;
        logic        hit;
        logic        err;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    string tag = "";

    task automatic push(input logic [1:0] m, input logic [23:0] mx, input logic [23:0] mn,
                        input logic c, input logic me, input logic ne, input logic h, input logic e);
        exp_t x;
        x.mode = m; x.max_out = mx; x.min_out = mn; x.carry_en = c;
        x.max_en = me; x.min_en = ne; x.hit = h; x.err = e;
        sb.push_back(x);
    endtask

    task automatic cmp(input string f, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s.%s got=%h exp=%h", tag, f, got, expv);
        end
    endtask

    task automatic check_now();
        exp_t x;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", tag);
            return;
        end
        x = sb.pop_front();
        cmp("mode",      32'(mode),      32'(x.mode));
        cmp("max_out",   32'(max_out),   32'(x.max_out));
        cmp("min_out",   32'(min_out),   32'(x.min_out));
        cmp("carry_en",  32'(carry_en),  32'(x.carry_en));
        cmp("max_en",    32'(max_en),    32'(x.max_en));
        cmp("min_en",    32'(min_en),    32'(x.min_en));
        cmp("limit_hit", 32'(limit_hit), 32'(x.hit));
        cmp("store_err", 32'(store_err), 32'(x.err));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_now();
    endtask

    initial begin
        reset = 1'b1; cnt_in = '0; mode_btn = 1'b0; store_max = 1'b0; store_min = 1'b0;
        tag = "reset"; push(2'd0, 24'h0, 24'h0, 0, 0, 0, 0, 0); step();
        reset = 1'b0;

        tag = "cap_adv"; cnt_in = 24'h000120; store_max = 1'b1; mode_btn = 1'b1;
        push(2'd1, 24'h000110, 24'h0, 1, 0, 0, 0, 0); step();
        tag = "held"; store_max = 1'b0;
        push(2'd1, 24'h000110, 24'h0, 1, 0, 0, 0, 0); step();
        tag = "rel"; mode_btn = 1'b0;
        push(2'd1, 24'h000110, 24'h0, 1, 0, 0, 0, 0); step();
        tag = "to_max"; mode_btn = 1'b1;
        push(2'd2, 24'h000120, 24'h0, 0, 1, 0, 0, 0); step();
        tag = "hold10"; cnt_in = 24'h000041;
        for (int i = 0; i < 10; i++) begin
            push(2'd2, 24'h000120, 24'h0, 0, 1, 0, 0, 0); step();
        end

        tag = "bad_bcd"; mode_btn = 1'b0; cnt_in = 24'h00A005; store_max = 1'b1;
        push(2'd2, 24'h000120, 24'h0, 0, 1, 0, 0, 1); step();
        tag = "err_clr"; store_max = 1'b0; cnt_in = 24'h000120;
        push(2'd2, 24'h000120, 24'h0, 0, 1, 0, 1, 0); step();

        tag = "cap42"; cnt_in = 24'h000042; store_max = 1'b1;
        push(2'd2, 24'h000042, 24'h0, 0, 1, 0, 0, 0); step();
        store_max = 1'b0;
        tag = "hit41"; cnt_in = 24'h000041; push(2'd2, 24'h000042, 24'h0, 0, 1, 0, 0, 0); step();
        tag = "hit42"; cnt_in = 24'h000042; push(2'd2, 24'h000042, 24'h0, 0, 1, 0, 1, 0); step();
        tag = "hit43"; cnt_in = 24'h000043; push(2'd2, 24'h000042, 24'h0, 0, 1, 0, 0, 0); step();

        tag = "min_bad"; store_min = 1'b1; cnt_in = 24'h00000B;
`ifdef LIMIT_WINDOW_EN
        push(2'd2, 24'h000042, 24'h0, 0, 1, 0, 0, 1); step();
`else
        push(2'd2, 24'h000042, 24'h0, 0, 1, 0, 0, 0); step();
`endif
        store_min = 1'b0;

        tag = "cap_carry"; cnt_in = 24'h050300; store_max = 1'b1;
        push(2'd2, 24'h050300, 24'h0, 0, 1, 0, 0, 0); step();
        store_max = 1'b0; cnt_in = 24'h0;
`ifdef LIMIT_WINDOW_EN
        tag = "to_win"; mode_btn = 1'b1; push(2'd3, 24'h050300, 24'h0, 0, 1, 1, 0, 0); step();
        mode_btn = 1'b0;                 push(2'd3, 24'h050300, 24'h0, 0, 1, 1, 0, 0); step();
        tag = "wrap"; mode_btn = 1'b1;   push(2'd0, 24'h0, 24'h0, 0, 0, 0, 0, 0); step();
        mode_btn = 1'b0;                 push(2'd0, 24'h0, 24'h0, 0, 0, 0, 0, 0); step();
`else
        tag = "wrap"; mode_btn = 1'b1;   push(2'd0, 24'h0, 24'h0, 0, 0, 0, 0, 0); step();
        mode_btn = 1'b0;                 push(2'd0, 24'h0, 24'h0, 0, 0, 0, 0, 0); step();
`endif
        tag = "carry"; mode_btn = 1'b1;  push(2'd1, 24'h010100, 24'h0, 1, 0, 0, 0, 0); step();
        mode_btn = 1'b0;                 push(2'd1, 24'h010100, 24'h0, 1, 0, 0, 0, 0); step();

`ifdef LIMIT_WINDOW_EN
        tag = "win_setup"; mode_btn = 1'b1; push(2'd2, 24'h050300, 24'h0, 0, 1, 0, 0, 0); step();
        mode_btn = 1'b0;                    push(2'd2, 24'h050300, 24'h0, 0, 1, 0, 0, 0); step();
        mode_btn = 1'b1;                    push(2'd3, 24'h050300, 24'h0, 0, 1, 1, 0, 0); step();
        mode_btn = 1'b0;
        tag = "win_min"; cnt_in = 24'h000200; store_min = 1'b1;
        push(2'd3, 24'h050300, 24'h000200, 0, 1, 1, 0, 0); step();
        store_min = 1'b0;
        tag = "win_inv"; cnt_in = 24'h000100; store_max = 1'b1;
        push(2'd3, 24'h000100, 24'h0, 0, 1, 0, 0, 0); step();
        store_max = 1'b0;
        tag = "win_inv_hit"; push(2'd3, 24'h000100, 24'h0, 0, 1, 0, 1, 0); step();
        tag = "win_ok"; cnt_in = 24'h000300; store_max = 1'b1;
        push(2'd3, 24'h000300, 24'h000200, 0, 1, 1, 0, 0); step();
        tag = "win_both_bad"; cnt_in = 24'h0000F0; store_min = 1'b1;
        push(2'd3, 24'h000300, 24'h000200, 0, 1, 1, 0, 1); step();
        store_max = 1'b0; store_min = 1'b0; cnt_in = 24'h0;
        tag = "win_err_clr"; push(2'd3, 24'h000300, 24'h000200, 0, 1, 1, 0, 0); step();
`endif

        // Asynchronous reset mid-cycle with a capture pending on the inputs.
        store_max = 1'b1; cnt_in = 24'h000777;
        #2;
        reset = 1'b1;
        #1;
        tag = "async_rst"; push(2'd0, 24'h0, 24'h0, 0, 0, 0, 0, 0); check_now();
        @(posedge clk);
        #1;
        tag = "rst_held"; push(2'd0, 24'h0, 24'h0, 0, 0, 0, 0, 0); check_now();
        reset = 1'b0; store_max = 1'b0; cnt_in = 24'h0;

        tag = "post_rst"; mode_btn = 1'b1; push(2'd1, 24'h0, 24'h0, 1, 0, 0, 0, 0); step();
        mode_btn = 1'b0;                   push(2'd1, 24'h0, 24'h0, 1, 0, 0, 0, 0); step();
        tag = "zero_max"; mode_btn = 1'b1; push(2'd2, 24'h0, 24'h0, 0, 1, 0, 0, 0); step();
        tag = "zero_hit"; mode_btn = 1'b0; push(2'd2, 24'h0, 24'h0, 0, 1, 0, 1, 0); step();
`ifdef LIMIT_WINDOW_EN
        tag = "zero_win"; mode_btn = 1'b1; push(2'd3, 24'h0, 24'h0, 0, 1, 1, 1, 0); step();
        mode_btn = 1'b0;
`endif

        tag = "drain";
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL %s leftover=%0d exp=0", tag, sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
